// File: rtl/instr_sequencer.sv
// Multi-cycle accumulator-machine sequencer: fetch/decode/execute over a memory
// with one cycle of registered read latency, plus STORE, SKIPCOND, JUMP and HALT.
module instr_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [15:0] ac,
  output logic        halted,
  output logic        instr_done,
  output logic        illegal_op,
  output logic        ovf
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_FETCH_RD,
    S_FETCH_LD,
    S_DECODE,
    S_OP_RD,
    S_OP_MBR,
    S_OP_EX,
    S_STORE,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OPC_LOAD     = 4'h1,
    OPC_STORE    = 4'h2,
    OPC_ADD      = 4'h3,
    OPC_SUBT     = 4'h4,
    OPC_HALT     = 4'h7,
    OPC_SKIPCOND = 4'h8,
    OPC_JUMP     = 4'h9,
    OPC_CLEAR    = 4'hA
  } opcode_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ac_q, ac_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mbr_q, mbr_d;
  logic        ovf_q, ovf_d;

  opcode_t     opcode;
  logic [15:0] operand;
  logic [15:0] sum;
  logic [15:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic        skip;
  logic        done_c;
  logic        illegal_c;

  assign opcode  = opcode_t'(ir_q[15:12]);
  assign operand = {4'h0, ir_q[11:0]};
  assign sum     = ac_q + mbr_q;
  assign diff    = ac_q - mbr_q;
  // Signed overflow: operands' signs agree (add) or differ (sub) and the result sign flips.
  assign add_ovf = (ac_q[15] == mbr_q[15]) && (sum[15]  != ac_q[15]);
  assign sub_ovf = (ac_q[15] != mbr_q[15]) && (diff[15] != ac_q[15]);

  always_comb begin
    skip = 1'b0;
    unique case (ir_q[11:10])
      2'b00:   skip = ac_q[15];
      2'b01:   skip = (ac_q == '0);
      2'b10:   skip = !ac_q[15] && (ac_q != '0);
      default: skip = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ac_q    <= '0;
      mar_q   <= '0;
      mbr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ac_q    <= ac_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    ac_d      = ac_q;
    mar_d     = mar_q;
    mbr_d     = mbr_q;
    ovf_d     = ovf_q;
    done_c    = 1'b0;
    illegal_c = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (run) begin
          mar_d   = pc_q;
          state_d = S_FETCH_RD;
        end
      end
      S_FETCH_RD: state_d = S_FETCH_LD;
      S_FETCH_LD: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + 16'd1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        mar_d   = operand;
        state_d = S_FETCH;
        case (opcode)
          OPC_LOAD, OPC_ADD, OPC_SUBT: state_d = S_OP_RD;
          OPC_STORE:                   state_d = S_STORE;
          OPC_HALT:                    state_d = S_HALT;
          OPC_JUMP: begin
            pc_d   = operand;
            done_c = 1'b1;
          end
          OPC_CLEAR: begin
            ac_d   = '0;
            done_c = 1'b1;
          end
          OPC_SKIPCOND: begin
            if (skip) pc_d = pc_q + 16'd1;
            done_c = 1'b1;
          end
          default: begin
            illegal_c = 1'b1;
            done_c    = 1'b1;
          end
        endcase
      end
      S_OP_RD: state_d = S_OP_MBR;
      S_OP_MBR: begin
        mbr_d   = mem_rdata;
        state_d = S_OP_EX;
      end
      S_OP_EX: begin
        done_c  = 1'b1;
        state_d = S_FETCH;
        case (opcode)
          OPC_LOAD: ac_d = mbr_q;
          OPC_ADD: begin
            ac_d  = sum;
            ovf_d = add_ovf;
          end
          OPC_SUBT: begin
            ac_d  = diff;
            ovf_d = sub_ovf;
          end
          default: ;
        endcase
      end
      S_STORE: begin
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are forced low while reset is held so no write can slip through mid-STORE.
  assign mem_we     = reset && (state_q == S_STORE);
  assign halted     = reset && (state_q == S_HALT);
  assign instr_done = reset && done_c;
  assign illegal_op = reset && illegal_c;

  assign mem_addr  = mar_q;
  assign mem_wdata = ac_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign ac        = ac_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction-level reference model checked every cycle,
// plus directed programs with hand-computed results.
module tb_instr_sequencer;

  localparam logic [15:0] RST_PC = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr, mem_wdata, pc, ir, ac;
  logic        mem_we, halted, instr_done, illegal_op, ovf;

  int n_pass = 0;
  int n_total = 0;

  instr_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .pc         (pc),
    .ir         (ir),
    .ac         (ac),
    .halted     (halted),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Program image (stimulus-owned) with a write overlay per program generation.
  logic [15:0] prog [0:65535];
  int          gen = 0;
  logic [15:0] w_over [int];
  int          w_gen = 0;

  function automatic logic [15:0] mem_peek(input logic [15:0] a);
    if (w_over.exists(int'(a))) return w_over[int'(a)];
    return prog[a];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (w_gen != gen) begin
        w_over.delete();
        w_gen = gen;
      end
      mem_rdata <= mem_peek(mem_addr);
      if (mem_we === 1'b1) w_over[int'(mem_addr)] = mem_wdata;
    end
  end

  // Reference model: one instruction at a time, with a latency per opcode class.
  logic [15:0] m_pc = '0, m_ac = '0, m_ir = '0, m_new = '0;
  logic        m_ovf = 1'b0, m_busy = 1'b0, m_halt = 1'b0, chk_en = 1'b0;
  int          m_k = 0, m_len = 4, m_gen = 0;
  logic [15:0] m_over [int];

  function automatic logic [15:0] m_rd(input logic [15:0] a);
    if (m_over.exists(int'(a))) return m_over[int'(a)];
    return prog[a];
  endfunction

  function automatic int latency(input logic [3:0] op);
    if (op == 4'h1 || op == 4'h3 || op == 4'h4) return 7;
    if (op == 4'h2) return 5;
    return 4;
  endfunction

  initial begin : model_p
    logic [3:0]  op;
    logic [15:0] a, e_pc, e_ir, opnd;
    logic        last, e_done, e_ill, e_we, e_halt, skip_it;
    int          r, v;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        op     = m_new[15:12];
        last   = m_busy && (m_k == m_len - 1);
        e_done = reset && last && (op != 4'h7);
        e_ill  = e_done && !(op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA});
        e_we   = e_done && (op == 4'h2);
        e_halt = reset && m_halt;
        e_pc   = m_pc;
        e_ir   = m_ir;
        if (m_busy && m_k >= 3) begin
          e_pc = m_pc + 16'd1;
          e_ir = m_new;
        end
        chk("pc", pc, e_pc);
        chk("ir", ir, e_ir);
        chk("ac", ac, m_ac);
        chk("ovf", 16'(ovf), 16'(m_ovf));
        chk("instr_done", 16'(instr_done), 16'(e_done));
        chk("illegal_op", 16'(illegal_op), 16'(e_ill));
        chk("mem_we", 16'(mem_we), 16'(e_we));
        chk("halted", 16'(halted), 16'(e_halt));
        if (e_we) begin
          chk("store_addr", mem_addr, {4'h0, m_new[11:0]});
          chk("store_data", mem_wdata, m_ac);
        end
      end

      if (m_gen != gen) begin
        m_over.delete();
        m_gen = gen;
      end
      if (!reset) begin
        m_pc = RST_PC; m_ac = '0; m_ir = '0; m_new = '0; m_ovf = 1'b0;
        m_busy = 1'b0; m_halt = 1'b0; m_k = 0; m_len = 4; chk_en = 1'b1;
      end else if (!m_halt) begin
        if (!m_busy) begin
          if (run) begin
            m_busy = 1'b1;
            m_k    = 1;
            m_new  = m_rd(m_pc);
            m_len  = latency(m_new[15:12]);
          end
        end else if (m_k == m_len - 1) begin
          a    = {4'h0, m_new[11:0]};
          opnd = m_rd(a);
          m_ir = m_new;
          m_pc = m_pc + 16'd1;
          v    = int'($signed(m_ac));
          case (m_new[15:12])
            4'h1: m_ac = opnd;
            4'h2: m_over[int'(a)] = m_ac;
            4'h3: begin
              r = v + int'($signed(opnd));
              m_ac = r[15:0];
              m_ovf = (r > 32767) || (r < -32768);
            end
            4'h4: begin
              r = v - int'($signed(opnd));
              m_ac = r[15:0];
              m_ovf = (r > 32767) || (r < -32768);
            end
            4'h7: m_halt = 1'b1;
            4'h8: begin
              case (m_new[11:10])
                2'b00:   skip_it = (v < 0);
                2'b01:   skip_it = (v == 0);
                2'b10:   skip_it = (v > 0);
                default: skip_it = 1'b0;
              endcase
              if (skip_it) m_pc = m_pc + 16'd1;
            end
            4'h9: m_pc = a;
            4'hA: m_ac = '0;
            default: ;
          endcase
          m_busy = 1'b0;
          m_k    = 0;
        end else begin
          m_k++;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_done(input int n, output logic ill);
    int seen;
    seen = 0;
    ill  = 1'b0;
    for (int c = 0; c < 60 && seen < n; c++) begin
      @(negedge clk);
      if (instr_done) begin
        seen++;
        ill = illegal_op;
      end
    end
    chk("done_wait", 16'(seen), 16'(n));
  endtask

  task automatic wait_halt(input int budget);
    for (int c = 0; c < budget && !halted; c++) @(negedge clk);
    chk("halt_wait", 16'(halted), 16'd1);
  endtask

  task automatic start_prog();
    reset = 1'b0;
    run   = 1'b0;
    gen++;
    for (int i = 0; i < 65536; i++) prog[i] = 16'h0000;
    prog[16'hFFFF] = 16'h9000;  // wrap-around fetch, then JUMP 000
  endtask

  initial begin
    logic ill;
    for (int i = 0; i < 65536; i++) prog[i] = 16'h0000;
    cyc(3);
    @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_ac", ac, 16'h0000);
    chk("rst_halted", 16'(halted), 16'd0);

    // run held low: sequencer parks in FETCH
    cyc(1);
    reset = 1'b1;
    cyc(6);
    @(negedge clk);
    chk("idle_pc", pc, RST_PC);
    chk("idle_we", 16'(mem_we), 16'd0);

    // LOAD/ADD/STORE/HALT program, with run dropped mid-JUMP
    cyc(1);
    start_prog();
    prog[16'h0000] = 16'h1010;
    prog[16'h0001] = 16'h3011;
    prog[16'h0002] = 16'h2012;
    prog[16'h0003] = 16'h7000;
    prog[16'h0010] = 16'h0005;
    prog[16'h0011] = 16'h0007;
    cyc(2);
    reset = 1'b1;
    run   = 1'b1;
    cyc(2);
    run = 1'b0;
    cyc(6);
    @(negedge clk);
    chk("jump_pc", pc, 16'h0000);
    chk("jump_ir", ir, 16'h9000);
    cyc(1);
    run = 1'b1;
    wait_halt(40);
    chk("progA_ac", ac, 16'h000C);
    chk("progA_pc", pc, 16'h0004);
    chk("progA_mem", mem_peek(16'h0012), 16'h000C);

    // overflow, CLEAR, illegal opcode and SKIPCOND
    cyc(1);
    start_prog();
    prog[16'h0000] = 16'h1020;
    prog[16'h0001] = 16'h3021;
    prog[16'h0002] = 16'h4021;
    prog[16'h0003] = 16'hA000;
    prog[16'h0004] = 16'hF123;
    prog[16'h0005] = 16'h8400;
    prog[16'h0006] = 16'h7000;
    prog[16'h0007] = 16'h8800;
    prog[16'h0008] = 16'h7000;
    prog[16'h0020] = 16'h7FFF;
    prog[16'h0021] = 16'h0001;
    cyc(2);
    reset = 1'b1;
    run   = 1'b1;
    wait_done(3, ill);
    @(negedge clk);
    chk("add_ac", ac, 16'h8000);
    chk("add_ovf", 16'(ovf), 16'd1);
    wait_done(1, ill);
    @(negedge clk);
    chk("sub_ac", ac, 16'h7FFF);
    chk("sub_ovf", 16'(ovf), 16'd1);
    wait_done(1, ill);
    @(negedge clk);
    chk("clear_ac", ac, 16'h0000);
    wait_done(1, ill);
    chk("illegal_pulse", 16'(ill), 16'd1);
    @(negedge clk);
    chk("illegal_pc", pc, 16'h0005);
    chk("illegal_ir", ir, 16'hF123);
    wait_done(1, ill);
    @(negedge clk);
    chk("skip_pc", pc, 16'h0007);
    wait_done(1, ill);
    @(negedge clk);
    chk("noskip_pc", pc, 16'h0008);
    wait_halt(20);
    cyc(1);
    run = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("halt_hold", 16'(halted), 16'd1);

    // reset asserted during the STORE cycle
    cyc(1);
    start_prog();
    prog[16'h0000] = 16'h1030;
    prog[16'h0001] = 16'h2031;
    prog[16'h0030] = 16'h1234;
    prog[16'h0031] = 16'hABCD;
    cyc(2);
    reset = 1'b1;
    run   = 1'b1;
    for (int c = 0; c < 40 && !mem_we; c++) cyc(1);
    chk("store_seen", 16'(mem_we), 16'd1);
    reset = 1'b0;
    #1;
    chk("we_in_reset", 16'(mem_we), 16'd0);
    cyc(1);
    @(negedge clk);
    chk("abort_pc", pc, RST_PC);
    chk("abort_ac", ac, 16'h0000);
    chk("abort_mem", mem_peek(16'h0031), 16'hABCD);
    cyc(1);
    reset = 1'b1;
    cyc(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset; sampled only at rising clk.
REQ-004 SHALL have port run  input  1  permits starting a new instruction when high.
REQ-005 SHALL have port mem_rdata  input  16  main-memory read data, registered in memory, valid one cycle after address presented.
REQ-006 SHALL have port mem_addr  output  16  memory address, driven directly from internal MAR.
REQ-007 SHALL have port mem_wdata  output  16  write data, equal to AC.
REQ-008 SHALL have port mem_we  output  1  memory write enable.
REQ-009 SHALL have port pc, ir, ac  output  16 each  program counter, instruction register, accumulator.
REQ-010 SHALL have port halted  output  1  high while in HALT state.
REQ-011 SHALL have port instr_done  output  1  one-cycle pulse on the final cycle of each completed instruction.
REQ-012 SHALL have port illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-013 SHALL have port ovf  output  1  signed overflow flag of the most recent ADD/SUBT.

Function
REQ-014 SHALL decode instructions as opcode ir[15:12] and operand address {4'h0, ir[11:0]}.
REQ-015 SHALL implement states FETCH, FETCH_RD, FETCH_LD, DECODE, OP_RD, OP_MBR, OP_EX, STORE, HALT.
REQ-016 FETCH: if run=1, MAR<=PC and go to FETCH_RD; if run=0, hold in FETCH with no register change.
REQ-017 FETCH_RD: no register update; go to FETCH_LD.
REQ-018 FETCH_LD: IR<=mem_rdata, PC<=PC+1 (16'hFFFF wraps to 16'h0000); go to DECODE.
REQ-019 DECODE: MAR<=operand address; next state is OP_RD for LOAD(1)/ADD(3)/SUBT(4), STORE for STORE(2), HALT for HALT(7), FETCH for all others.
REQ-020 DECODE, JUMP(9): PC<=operand address; instr_done=1.
REQ-021 DECODE, CLEAR(A): AC<=16'h0000; instr_done=1.
REQ-022 DECODE, SKIPCOND(8): ir[11:10]=00 skip if AC signed <0; 01 skip if AC==0; 10 skip if AC signed >0; 11 never skip; skip means PC<=PC+1 with wrap; instr_done=1.
REQ-023 DECODE, any other opcode: no architectural change; illegal_op=1 and instr_done=1 in the same cycle.
REQ-024 OP_RD: no register update; go to OP_MBR. OP_MBR: MBR<=mem_rdata; go to OP_EX.
REQ-025 OP_EX: LOAD AC<=MBR; ADD AC<=AC+MBR; SUBT AC<=AC-MBR, all modulo 2^16; instr_done=1; go to FETCH.
REQ-026 ADD/SUBT SHALL set ovf to two's-complement signed overflow of that operation; LOAD and other opcodes leave ovf unchanged.
REQ-027 STORE state: mem_we=1, mem_addr=MAR, mem_wdata=AC for exactly one cycle; instr_done=1; go to FETCH.
REQ-028 mem_we SHALL be 0 in every state other than STORE, and 0 in any cycle where reset=0.
REQ-029 HALT: halted=1; remain in HALT regardless of run until reset.
REQ-030 Latency from FETCH with run=1 to instr_done: JUMP/CLEAR/SKIPCOND/illegal 4 cycles, STORE 5, LOAD/ADD/SUBT 7.
REQ-031 run SHALL be sampled only in FETCH; deassertion mid-instruction SHALL NOT stall it.

Reset
REQ-032 When reset=0 at a rising edge: state<=FETCH, PC<=RESET_PC, IR, AC, MAR, MBR<=16'h0000, ovf<=0, from any state including mid-instruction and HALT.
REQ-033 While reset=0: halted, instr_done, illegal_op and mem_we SHALL all be 0.

Verification
REQ-034 mem[0..3]=1010,3011,2012,7000 (hex), mem[010]=0005, mem[011]=0007, run=1 -> mem[012]=000C, ac=000C, pc=0004, halted=1 within 23 cycles after reset release.
REQ-035 AC=7FFF, ADD of word 0001 -> ac=8000, ovf=1; then SUBT of word 0001 -> ac=7FFF, ovf=1.
REQ-036 AC=0000, SKIPCOND 8400 at pc=0005 -> pc=0007; SKIPCOND 8800 with AC=0000 -> no skip.
REQ-037 Opcode F fetched -> one-cycle illegal_op and instr_done, ac/pc otherwise unchanged except pc+1.
REQ-038 reset=0 asserted during STORE state -> mem_we=0 that cycle, memory unchanged, pc=RESET_PC, ac=0000 next cycle.
REQ-039 run=0 after reset -> FETCH held, mem_we=0, pc stays at RESET_PC indefinitely; pc=FFFF fetch -> pc wraps to 0000.
